mips_ma: RTL and testbench
==========================

Name: mips_ma

Overview:
- Memory-access/write-back stage of the MIPS I core, directly downstream of the execute stage.
- Consumes the execute result D (ALU result or effective address) and store operand T.
- Runs single-outstanding load/store transactions on a req/ack data bus, aligns byte lanes, and sign/zero-extends loads.
- Issues register-file write-back, address-error pulses, and back-pressure (stall) to the upstream stages.

Parameters:
- BIG_ENDIAN, 0, byte-lane order; 0 = little-endian, 1 = big-endian (lane index XOR 3 for bytes, XOR 2 for halves).

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- valid  in  1  execute result present this cycle
- kind  in  2  0 = ALU (write-back only), 1 = load, 2 = store, 3 = nop
- size  in  2  0 = byte, 1 = half, 3 = word; 2 reserved, treated as word
- sign  in  1  1 = sign-extend load, 0 = zero-extend
- D  in  32  ALU result or effective address
- T  in  32  store data (rt)
- rd  in  5  destination register
- stall  out  1  upstream must hold its outputs
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte enables, bit i = lane i (bits [8i+7:8i])
- mem_wdata  out  32  write data
- mem_ack  in  1  transfer complete this cycle
- mem_rdata  in  32  read data, valid when mem_ack = 1
- wb_en  out  1  register-file write strobe
- wb_reg  out  5  write-back register
- wb_data  out  32  write-back value
- adel  out  1  load address-error pulse
- ades  out  1  store address-error pulse
- bad_va  out  32  faulting virtual address

Behaviour:
- Reset (asynchronous): state IDLE. mem_req, mem_we, wb_en, adel, ades = 0. mem_addr, mem_be, mem_wdata, wb_reg, wb_data, bad_va = 0.
- Reset mid-transaction: mem_req drops immediately and the pending load/store is discarded. The bus must tolerate an abandoned request.
- States:
  - IDLE: accept when valid && !stall.
  - BUS: request outstanding.
- stall = (state == BUS) && !mem_ack. Upstream may present the next operation in the ack cycle; it is accepted at that same edge.
- Accept, ALU kind: at the next edge, wb_en = (rd != 0), wb_reg = rd, wb_data = D. Latency 1 cycle, no stall.
- Accept, nop kind or valid = 0: wb_en = 0 at the next edge.
- Alignment check at accept:
  - half requires D[0] = 0; word requires D[1:0] = 0.
  - Misaligned load: adel = 1 for exactly one cycle (registered, same timing as wb_en), bad_va = D, no bus cycle, no write-back.
  - Misaligned store: same, using ades.
- Aligned load or store at accept:
  - Register mem_addr = {D[31:2], 2'b00}, mem_be, mem_we, mem_wdata; set mem_req = 1; go to BUS.
  - All bus outputs stay stable while in BUS.
- Byte enables and write data:
  - byte: lane = D[1:0] (XOR 3 if BIG_ENDIAN); mem_be = 1 << lane; mem_wdata = {4{T[7:0]}}.
  - half: lane pair = D[1] (XOR 1 if BIG_ENDIAN); mem_be = 4'b0011 or 4'b1100; mem_wdata = {2{T[15:0]}}.
  - word: mem_be = 4'b1111; mem_wdata = T.
- BUS with mem_ack = 1:
  - At that edge: mem_req = 0, state IDLE (or back to BUS if a new memory op is accepted in the same cycle).
  - Load: wb_en = (rd != 0); wb_data = the selected lane, sign- or zero-extended to 32 bits.
  - Store: wb_en = 0.
- Load-to-write-back latency: wb_en is high in the cycle after ack. Minimum total latency is 2 cycles after accept, for ack in the first BUS cycle.
- Pulse width: wb_en, adel, ades are single-cycle pulses; they are 0 in every cycle without a completing event.
- rd = 0: never asserts wb_en. The bus transaction still occurs for loads.
- mem_ack while in IDLE is ignored.

Decomposition:
- Shared package (mips_pkg): kind codes (MA_ALU, MA_LOAD, MA_STORE, MA_NOP) and size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
- One combinational sub-module, mips_lane (parameter BIG_ENDIAN):
  - Inputs: size, sign, addr[1:0], T, rdata.
  - Outputs: be, wdata, load value, misaligned flag.
  - Used by mips_ma for both directions.

Test Plan:
- Reset mid-BUS: load accepted, reset asserted before ack -> mem_req = 0 asynchronously; after release, wb_en stays 0 and the late ack is ignored.
- ALU pass-through: kind = 0, D = 32'h1234_5678, rd = 5 -> next cycle wb_en = 1, wb_reg = 5, wb_data = 32'h1234_5678, stall = 0. Same with rd = 0 -> wb_en = 0.
- Signed byte load, little-endian: D = 32'h0000_1003, sign = 1, ack after 3 BUS cycles with rdata = 32'h80AA_BBCC:
  - Bus: mem_addr = 32'h0000_1000, mem_be = 4'b1000, stall high for 3 cycles.
  - Then: wb_data = 32'hFFFF_FF80.
  - Repeat with sign = 0 -> wb_data = 32'h0000_0080.
- Half store, both endian settings: D = 32'h2002, T = 32'hDEAD_BEEF -> mem_we = 1, mem_wdata = 32'hBEEF_BEEF; mem_be = 4'b1100 (LE) or 4'b0011 (BE); no wb_en.
- Misaligned accesses:
  - Word load at D = 32'h0000_0006 -> adel pulse one cycle, bad_va = 32'h0000_0006, mem_req never asserts.
  - Half store at D = 32'h1 -> ades pulse, bad_va = 32'h1.
- Back-to-back: load acked in its first BUS cycle while a store is presented in the ack cycle -> store accepted at the ack edge, mem_req stays high with new mem_addr/mem_be, and the load's wb_en pulses the same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS I memory-access stage: operation kinds,
// access sizes and the stage FSM states.
package mips_pkg;

  typedef enum logic [1:0] {
    MA_ALU   = 2'd0,
    MA_LOAD  = 2'd1,
    MA_STORE = 2'd2,
    MA_NOP   = 2'd3
  } kind_t;

  // Size code 2 is reserved and decodes as a word access.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } ma_state_t;

endpackage

// File: rtl/mips_lane.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// lane selection plus sign/zero extension for loads, and alignment check.
module mips_lane
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [1:0]  w_lane;
  logic        w_hi;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_lane = addr ^ (BIG_ENDIAN ? 2'd3 : 2'd0);
  assign w_hi   = addr[1] ^ BIG_ENDIAN;
  assign w_byte = rdata[{w_lane, 3'b000} +: 8];
  assign w_half = w_hi ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata      = wdata_in;
    load_val   = rdata;
    misaligned = |addr;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << w_lane;
        wdata      = {4{wdata_in[7:0]}};
        load_val   = {{24{sign & w_byte[7]}}, w_byte};
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        be         = w_hi ? 4'b1100 : 4'b0011;
        wdata      = {2{wdata_in[15:0]}};
        load_val   = {{16{sign & w_half[15]}}, w_half};
        misaligned = addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_ma.sv
// MIPS I memory-access / write-back stage: one outstanding req/ack bus
// transaction at a time, lane alignment, load extension and address errors.
module mips_ma
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  kind,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] D,
  input  logic [31:0] T,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_va,
  output ma_state_t   dbg_state
);

  ma_state_t   r_state;
  logic        r_is_load;
  logic        r_ld_sign;
  logic [1:0]  r_ld_size;
  logic [1:0]  r_ld_lo;
  logic [4:0]  r_ld_rd;

  logic        w_accept, w_done;
  logic [3:0]  w_acc_be, w_ld_be;
  logic [31:0] w_acc_wdata, w_acc_load, w_ld_wdata, w_ld_val;
  logic        w_acc_mis, w_ld_mis;
  logic        w_unused_lane;

  assign stall     = (r_state == ST_BUS) && !mem_ack;
  assign w_accept  = valid && !stall;
  assign w_done    = (r_state == ST_BUS) && mem_ack;
  assign dbg_state = r_state;

  // Accept side works on the incoming operation; load side on the op in flight.
  mips_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_acc (
    .size(size), .sign(sign), .addr(D[1:0]), .wdata_in(T), .rdata(mem_rdata),
    .be(w_acc_be), .wdata(w_acc_wdata), .load_val(w_acc_load), .misaligned(w_acc_mis)
  );

  mips_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_ld (
    .size(r_ld_size), .sign(r_ld_sign), .addr(r_ld_lo), .wdata_in(T), .rdata(mem_rdata),
    .be(w_ld_be), .wdata(w_ld_wdata), .load_val(w_ld_val), .misaligned(w_ld_mis)
  );

  assign w_unused_lane = ^{w_acc_load, w_ld_be, w_ld_wdata, w_ld_mis};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_is_load <= 1'b0;
      r_ld_sign <= 1'b0;
      r_ld_size <= 2'd0;
      r_ld_lo   <= 2'd0;
      r_ld_rd   <= 5'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      wb_en     <= 1'b0;
      wb_reg    <= 5'd0;
      wb_data   <= 32'd0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      bad_va    <= 32'd0;
    end else begin
      wb_en <= 1'b0;
      adel  <= 1'b0;
      ades  <= 1'b0;
      if (w_done) begin
        mem_req <= 1'b0;
        r_state <= ST_IDLE;
      end
      if (w_accept) begin
        case (kind_t'(kind))
          MA_ALU: begin
            wb_en   <= (rd != 5'd0);
            wb_reg  <= rd;
            wb_data <= D;
          end
          MA_LOAD, MA_STORE: begin
            if (w_acc_mis) begin
              adel   <= (kind_t'(kind) == MA_LOAD);
              ades   <= (kind_t'(kind) == MA_STORE);
              bad_va <= D;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (kind_t'(kind) == MA_STORE);
              mem_addr  <= {D[31:2], 2'b00};
              mem_be    <= w_acc_be;
              mem_wdata <= w_acc_wdata;
              r_state   <= ST_BUS;
              r_is_load <= (kind_t'(kind) == MA_LOAD);
              r_ld_sign <= sign;
              r_ld_size <= size;
              r_ld_lo   <= D[1:0];
              r_ld_rd   <= rd;
            end
          end
          default: ;
        endcase
      end
      // A completing load owns the single write port if an ALU op lands in its ack cycle.
      if (w_done && r_is_load) begin
        wb_en   <= (r_ld_rd != 5'd0);
        wb_reg  <= r_ld_rd;
        wb_data <= w_ld_val;
      end
    end
  end

endmodule

// File: tb/tb_mips_ma.sv
// Directed bench for mips_ma: little-endian and big-endian instances share
// stimulus; every check is an immediate assertion against a hand-computed value.
module tb_mips_ma;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  kind = 2'd3;
  logic [1:0]  size = 2'd0;
  logic        sign = 1'b0;
  logic [31:0] D = '0;
  logic [31:0] T = '0;
  logic [4:0]  rd = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        stall, mem_req, mem_we, wb_en, adel, ades;
  logic [31:0] mem_addr, mem_wdata, wb_data, bad_va;
  logic [3:0]  mem_be;
  logic [4:0]  wb_reg;
  ma_state_t   dbg_state;

  logic        stall_b, mem_req_b, mem_we_b, wb_en_b, adel_b, ades_b;
  logic [31:0] mem_addr_b, mem_wdata_b, wb_data_b, bad_va_b;
  logic [3:0]  mem_be_b;
  logic [4:0]  wb_reg_b;
  ma_state_t   dbg_state_b;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mips_ma #(.BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset(reset), .valid(valid), .kind(kind), .size(size),
    .sign(sign), .D(D), .T(T), .rd(rd), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .adel(adel), .ades(ades), .bad_va(bad_va),
    .dbg_state(dbg_state)
  );

  mips_ma #(.BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset(reset), .valid(valid), .kind(kind), .size(size),
    .sign(sign), .D(D), .T(T), .rd(rd), .stall(stall_b), .mem_req(mem_req_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_be(mem_be_b), .mem_wdata(mem_wdata_b),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en_b), .wb_reg(wb_reg_b),
    .wb_data(wb_data_b), .adel(adel_b), .ades(ades_b), .bad_va(bad_va_b),
    .dbg_state(dbg_state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [1:0] sz,
                       input logic sg, input logic [31:0] d, input logic [31:0] t,
                       input logic [4:0] r);
    valid = v; kind = k; size = sz; sign = sg; D = d; T = t; rd = r;
  endtask

  task automatic idle();
    drive(1'b0, MA_NOP, SZ_WORD, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_adel_ades", {adel, ades}, 2'b00);
    chk("rst_bad_va", bad_va, 32'd0);
    chk("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // ALU pass-through, then rd = 0
    drive(1'b1, MA_ALU, SZ_WORD, 1'b0, 32'h1234_5678, 32'd0, 5'd5);
    #1;
    chk("alu_stall", stall, 1'b0);
    tick();
    drive(1'b1, MA_ALU, SZ_WORD, 1'b0, 32'hAAAA_0000, 32'd0, 5'd0);
    chk("alu_wb_en", wb_en, 1'b1);
    chk("alu_wb_reg", wb_reg, 5'd5);
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    tick();
    idle();
    chk("alu_rd0_wb_en", wb_en, 1'b0);
    tick();
    chk("alu_pulse_end", wb_en, 1'b0);

    // Signed byte load at 0x1003, ack in the 4th BUS cycle
    drive(1'b1, MA_LOAD, SZ_BYTE, 1'b1, 32'h0000_1003, 32'd0, 5'd7);
    tick();
    idle();
    chk("lb_mem_req", mem_req, 1'b1);
    chk("lb_mem_we", mem_we, 1'b0);
    chk("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk("lb_mem_be", mem_be, 4'b1000);
    chk("lb_mem_be_big", mem_be_b, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", stall, 1'b1);
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h80AA_BBCC;
    #1;
    chk("lb_ack_stall", stall, 1'b0);
    tick();
    mem_ack = 1'b0;
    chk("lb_wb_en", wb_en, 1'b1);
    chk("lb_wb_reg", wb_reg, 5'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_data_big", wb_data_b, 32'hFFFF_FFCC);
    chk("lb_req_drop", mem_req, 1'b0);
    tick();
    chk("lb_wb_pulse", wb_en, 1'b0);

    // Same load zero-extended, ack in the first BUS cycle
    drive(1'b1, MA_LOAD, SZ_BYTE, 1'b0, 32'h0000_1003, 32'd0, 5'd7);
    tick();
    idle();
    mem_ack = 1'b1;
    mem_rdata = 32'h80AA_BBCC;
    tick();
    mem_ack = 1'b0;
    chk("lbu_wb_en", wb_en, 1'b1);
    chk("lbu_wb_data", wb_data, 32'h0000_0080);

    // Half store at 0x2002 on both byte orders
    drive(1'b1, MA_STORE, SZ_HALF, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3);
    tick();
    idle();
    chk("sh_mem_we", mem_we, 1'b1);
    chk("sh_mem_addr", mem_addr, 32'h0000_2000);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_be_le", mem_be, 4'b1100);
    chk("sh_be_be", mem_be_b, 4'b0011);
    chk("sh_wdata_be", mem_wdata_b, 32'hBEEF_BEEF);
    tick();
    chk("sh_hold_addr", mem_addr, 32'h0000_2000);
    chk("sh_hold_be", mem_be, 4'b1100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_no_wb", wb_en, 1'b0);
    chk("sh_req_drop", mem_req, 1'b0);

    // Misaligned word load
    drive(1'b1, MA_LOAD, SZ_WORD, 1'b0, 32'h0000_0006, 32'd0, 5'd8);
    tick();
    idle();
    chk("adel_pulse", adel, 1'b1);
    chk("adel_ades", ades, 1'b0);
    chk("adel_bad_va", bad_va, 32'h0000_0006);
    chk("adel_no_req", mem_req, 1'b0);
    chk("adel_no_wb", wb_en, 1'b0);
    tick();
    chk("adel_pulse_end", adel, 1'b0);
    chk("adel_no_req2", mem_req, 1'b0);

    // Misaligned half store
    drive(1'b1, MA_STORE, SZ_HALF, 1'b0, 32'h0000_0001, 32'h1111_2222, 5'd0);
    tick();
    idle();
    chk("ades_pulse", ades, 1'b1);
    chk("ades_adel", adel, 1'b0);
    chk("ades_bad_va", bad_va, 32'h0000_0001);
    chk("ades_no_req", mem_req, 1'b0);
    tick();
    chk("ades_pulse_end", ades, 1'b0);

    // Back-to-back: store presented in the ack cycle of a word load
    drive(1'b1, MA_LOAD, SZ_WORD, 1'b1, 32'h0000_0040, 32'd0, 5'd9);
    tick();
    drive(1'b1, MA_STORE, SZ_WORD, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 5'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1122_3344;
    #1;
    chk("b2b_stall", stall, 1'b0);
    tick();
    mem_ack = 1'b0;
    idle();
    chk("b2b_req", mem_req, 1'b1);
    chk("b2b_addr", mem_addr, 32'h0000_0080);
    chk("b2b_we", mem_we, 1'b1);
    chk("b2b_be", mem_be, 4'b1111);
    chk("b2b_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("b2b_wb_en", wb_en, 1'b1);
    chk("b2b_wb_reg", wb_reg, 5'd9);
    chk("b2b_wb_data", wb_data, 32'h1122_3344);
    chk("b2b_state", dbg_state, ST_BUS);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_req_drop", mem_req, 1'b0);
    chk("b2b_store_no_wb", wb_en, 1'b0);

    // Load to rd = 0: bus cycle happens, no write-back
    drive(1'b1, MA_LOAD, SZ_WORD, 1'b0, 32'h0000_0200, 32'd0, 5'd0);
    tick();
    idle();
    chk("rd0_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    chk("rd0_no_wb", wb_en, 1'b0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_wb", wb_en, 1'b0);
    chk("idle_ack_state", dbg_state, ST_IDLE);

    // Reset in the middle of a bus transaction
    drive(1'b1, MA_LOAD, SZ_WORD, 1'b0, 32'h0000_0100, 32'd0, 5'd4);
    tick();
    idle();
    chk("rst_bus_req", mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_req", mem_req, 1'b0);
    chk("rst_async_state", dbg_state, ST_IDLE);
    @(negedge clock);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    chk("rst_late_ack_wb", wb_en, 1'b0);
    chk("rst_late_ack_req", mem_req, 1'b0);
    chk("rst_late_ack_state", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
